// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// also used by the baud generator.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: line and tick in, byte and strobes out, FSM state for observation.
// Handshake: rx_done is a valid-only pulse with no ready; a consumer that misses it loses the byte.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_err;
  rx_state_t            state;

  modport master (
    output tick, rx,
    input  rx_data, rx_done, frame_err, state
  );

  modport slave (
    input  tick, rx,
    output rx_data, rx_done, frame_err, state
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 so an idle-high line
// reads idle during and right after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start-bit qualification, 3-sample majority per bit,
// one-cycle rx_done / frame_err strobes, and break recovery.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_S0    = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] CNT_S1    = CW'(OVERSAMPLE - 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 err_q;
  logic                 maj;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // The third sample is the live rx_s on the final tick of the bit.
  assign maj = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      s0      <= 1'b0;
      s1      <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == CNT_MID) begin
              cnt <= '0;
              if (!rx_s) begin
                bit_idx <= '0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == CNT_S0) s0 <= rx_s;
            if (cnt == CNT_S1) s1 <= rx_s;
            if (cnt == CNT_LAST) begin
              shift   <= {maj, shift[DATA_BITS-1:1]};
              cnt     <= '0;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == CNT_S0) s0 <= rx_s;
            if (cnt == CNT_S1) s1 <= rx_s;
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (maj) begin
                data_q <= shift;
                done_q <= 1'b1;
                state  <= IDLE;
              end else begin
                err_q <= 1'b1;
                state <= RECOVER;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RECOVER: begin
            // Wait out a held-low break so it is not decoded as a stream of zero bytes.
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = err_q;
  assign bus.state     = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: tick every 4 clk, 16 ticks per bit, scoreboard of expected bytes.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk;
  logic rst_n;
  logic [1:0] div;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset / tick ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial div = 2'd0;
  always @(posedge clk) begin
    div      <= div + 2'd1;
    bus.tick <= (div == 2'd3);
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  int compared;
  int mismatched;
  int done_cnt;
  int err_cnt;
  logic prev_done;
  logic prev_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (bus.rx_done && bus.frame_err) begin
        compared++;
        mismatched++;
        $display("FAIL strobe_excl: rx_done=1 frame_err=1, required not both");
      end
      if (bus.rx_done) begin
        done_cnt++;
        compared++;
        if (prev_done) begin
          mismatched++;
          $display("FAIL done_width: rx_done high 2 cycles, required 1");
        end else if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done: got rx_data=%02h, required no frame", bus.rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          last_good = e;
          if (bus.rx_data !== e) begin
            mismatched++;
            $display("FAIL rx_data: got %02h, required %02h", bus.rx_data, e);
          end
        end
      end
      if (bus.frame_err) begin
        err_cnt++;
        compared++;
        if (prev_err) begin
          mismatched++;
          $display("FAIL err_width: frame_err high 2 cycles, required 1");
        end else if (bus.rx_data !== last_good) begin
          mismatched++;
          $display("FAIL data_hold_on_err: got %02h, required %02h", bus.rx_data, last_good);
        end
      end
      prev_done = bus.rx_done;
      prev_err  = bus.frame_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (!bus.tick) @(negedge clk);
    end
  endtask

  // Drives one frame; glitch_bit >= 0 inverts the line for the single tick that
  // lands on the middle majority sample of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int glitch_bit);
    wait_ticks(1);
    if (stop_val) exp_q.push_back(b);
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int j = 0; j < 8; j++) begin
      bus.rx = b[j];
      if (j == glitch_bit) begin
        wait_ticks(7);
        bus.rx = ~b[j];
        wait_ticks(1);
        bus.rx = b[j];
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    bus.rx = stop_val;
    wait_ticks(16);
  endtask

  task automatic check_counts(input string name, input int d0, input int e0,
                              input int dd, input int de);
    compared++;
    if (done_cnt - d0 !== dd) begin
      mismatched++;
      $display("FAIL %s_done_count: got %0d, required %0d", name, done_cnt - d0, dd);
    end
    compared++;
    if (err_cnt - e0 !== de) begin
      mismatched++;
      $display("FAIL %s_err_count: got %0d, required %0d", name, err_cnt - e0, de);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.rx_data !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_rx_data: got %02h, required 00", bus.rx_data);
    end
    compared++;
    if (bus.rx_done !== 1'b0 || bus.frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: got done=%b err=%b, required 0 0", bus.rx_done, bus.frame_err);
    end
    compared++;
    if (bus.state !== IDLE) begin
      mismatched++;
      $display("FAIL reset_state: got %0d, required %0d", bus.state, IDLE);
    end
    rst_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, -1);
    wait_ticks(4);
    check_counts("basic", d0, e0, 1, 0);
  endtask

  task automatic test_glitch();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    wait_ticks(1);
    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(16);
    compared++;
    if (bus.state !== IDLE) begin
      mismatched++;
      $display("FAIL glitch_state: got %0d, required %0d", bus.state, IDLE);
    end
    check_counts("glitch", d0, e0, 0, 0);
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1, -1);
    wait_ticks(4);
    check_counts("glitch_follow", d0, e0, 1, 0);
  endtask

  task automatic test_break();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, -1);
    wait_ticks(40 * 16 - 16);
    compared++;
    if (bus.state !== RECOVER) begin
      mismatched++;
      $display("FAIL break_state: got %0d, required %0d", bus.state, RECOVER);
    end
    check_counts("break", d0, e0, 0, 1);
    bus.rx = 1'b1;
    wait_ticks(32);
    send_frame(8'h5A, 1'b1, -1);
    wait_ticks(4);
    check_counts("break_follow", d0, e0, 1, 1);
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_ticks(4);
    check_counts("b2b", d0, e0, 2, 0);
  endtask

  task automatic test_majority();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1, 4);
    wait_ticks(4);
    check_counts("majority", d0, e0, 1, 0);
  endtask

  task automatic test_reset_midframe();
    int d0, e0;
    logic [7:0] b;
    b = 8'hC6;
    wait_ticks(1);
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int j = 0; j < 3; j++) begin
      bus.rx = b[j];
      wait_ticks(16);
    end
    bus.rx = b[3];
    wait_ticks(5);
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.rx_data !== 8'h00 || bus.rx_done !== 1'b0 || bus.frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got data=%02h done=%b err=%b, required 00 0 0",
               bus.rx_data, bus.rx_done, bus.frame_err);
    end
    compared++;
    if (bus.state !== IDLE) begin
      mismatched++;
      $display("FAIL midreset_state: got %0d, required %0d", bus.state, IDLE);
    end
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    d0 = done_cnt; e0 = err_cnt;
    wait_ticks(32);
    check_counts("midreset_idle", d0, e0, 0, 0);
    send_frame(8'h81, 1'b1, -1);
    wait_ticks(4);
    check_counts("midreset_follow", d0, e0, 1, 0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    compared   = 0;
    mismatched = 0;
    done_cnt   = 0;
    err_cnt    = 0;
    last_good  = 8'h00;
    prev_done  = 1'b0;
    prev_err   = 1'b0;
    bus.tick   = 1'b0;
    bus.rx     = 1'b1;
    rst_n      = 1'b0;

    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_majority();
    test_reset_midframe();

    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL pending_frames: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
